// File: rtl/theta_page_sequencer.sv
// Purpose : walks all PAGES lanes of the state memory, feeding page z and page (z-1) mod PAGES
//           to an external parity unit and writing its result back to page z in place.
// Ports   : start/busy/done control; sync-read page memory (mem_raddr -> mem_rdata one cycle
//           later) plus write port; cal_start/cal_finish handshake; cur_page/prev_page/parity_out.
// Timing  : 3 + PAGES*(4 + W) cycles from start to done, where W >= 1 is the WAIT length per page.
//           Backpressure comes only from cal_finish, with no timeout; start is ignored while busy.
module theta_page_sequencer #(
    parameter int PAGES = 64,
    parameter int AW    = 6     // PAGES must equal 2**AW so z wraps naturally
) (
    input  logic          clk,
    input  logic          rst,        // asynchronous, active-low
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] mem_raddr,
    input  logic [0:24]   mem_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_waddr,
    output logic [0:24]   mem_wdata,
    output logic          cal_start,
    input  logic          cal_finish,
    output logic [0:24]   cur_page,
    output logic [0:24]   prev_page,
    input  logic [0:24]   parity_out
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_LAST,
        S_CAP_LAST,
        S_RD_CUR,
        S_CAP_CUR,
        S_CALC,
        S_WAIT,
        S_WRITE,
        S_FIN
    } state_t;

    localparam logic [AW-1:0] LAST_PAGE = AW'(PAGES - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] z_q, z_d;
    logic [0:24]   prev_q, prev_d;
    logic [0:24]   cur_q, cur_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          we_q, we_d;
    logic          cal_start_q, cal_start_d;
    logic [AW-1:0] raddr_q, raddr_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [0:24]   wdata_q, wdata_d;

    // Next state and datapath registers.
    always_comb begin
        state_d = state_q;
        z_d     = z_q;
        prev_d  = prev_q;
        cur_d   = cur_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD_LAST;
                    z_d     = '0;
                end
            end
            S_RD_LAST:  state_d = S_CAP_LAST;
            S_CAP_LAST: begin
                // Neighbour of page 0 is the original last page, read before anything is written.
                prev_d  = mem_rdata;
                state_d = S_RD_CUR;
            end
            S_RD_CUR:   state_d = S_CAP_CUR;
            S_CAP_CUR: begin
                cur_d   = mem_rdata;
                state_d = S_CALC;
            end
            S_CALC:     state_d = S_WAIT;
            S_WAIT: begin
                if (cal_finish) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Current page becomes the neighbour of the next one, so no re-read is needed
                // and the in-place write never pollutes an operand.
                prev_d = cur_q;
                if (z_q == LAST_PAGE) begin
                    state_d = S_FIN;
                end else begin
                    z_d     = z_q + AW'(1);
                    state_d = S_RD_CUR;
                end
            end
            S_FIN:      state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Outputs are registered: they are decoded from the state being entered so that each
    // output is valid exactly during the cycle its state occupies.
    always_comb begin
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_FIN);
        cal_start_d = (state_d == S_CALC);
        we_d        = (state_d == S_WRITE);
        raddr_d     = '0;
        if (state_d == S_RD_LAST) begin
            raddr_d = LAST_PAGE;
        end else if (state_d == S_RD_CUR) begin
            raddr_d = z_d;
        end
        // The parity result is taken on the cal_finish cycle and held through WRITE.
        waddr_d = we_d ? z_d : '0;
        wdata_d = we_d ? parity_out : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            z_q         <= '0;
            prev_q      <= '0;
            cur_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            cal_start_q <= 1'b0;
            raddr_q     <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            z_q         <= z_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            we_q        <= we_d;
            cal_start_q <= cal_start_d;
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_we    = we_q;
    assign cal_start = cal_start_q;
    assign mem_raddr = raddr_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;
    assign cur_page  = cur_q;
    assign prev_page = prev_q;

endmodule

// File: tb/tb_theta_page_sequencer.sv
// Purpose : exercises theta_page_sequencer against a page-array reference model.
// Timing  : inputs driven 1 time unit after the rising edge, outputs observed on the falling edge.
// Model   : parity unit answers cal_finish N+1 cycles into WAIT (or immediately when held high).
module tb_theta_page_sequencer;

    localparam int PAGES = 64;
    localparam int AW    = 6;

    logic          clk;
    logic          rst;
    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] mem_raddr;
    logic [0:24]   mem_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [0:24]   mem_wdata;
    logic          cal_start;
    logic          cal_finish;
    logic [0:24]   cur_page;
    logic [0:24]   prev_page;
    logic [0:24]   parity_out;

    theta_page_sequencer #(.PAGES(PAGES), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_raddr  (mem_raddr),
        .mem_rdata  (mem_rdata),
        .mem_we     (mem_we),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .cal_start  (cal_start),
        .cal_finish (cal_finish),
        .cur_page   (cur_page),
        .prev_page  (prev_page),
        .parity_out (parity_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- environment models ----------------
    logic [0:24] mem    [PAGES];
    logic [0:24] orig   [PAGES];
    logic [0:24] exp_pg [PAGES];
    int          cyc = 0;
    int          cnt = 0;
    int          wait_n = 1;
    logic        hold_hi = 1'b0;
    logic        mode_prev = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        mem_rdata <= mem[mem_raddr];
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (cal_start) cnt <= wait_n + 1;
        else if (cnt > 0) cnt <= cnt - 1;
    end

    assign cal_finish = hold_hi || (cnt == 1);
    assign parity_out = mode_prev ? prev_page : (cur_page ^ prev_page);

    // ---------------- monitor ----------------
    logic mon_en = 1'b0;
    logic cal_prev = 1'b0;
    int   wr_idx = 0;
    int   ncal = 0;
    int   ndone = 0;
    int   done_k = -1;
    int   k0 = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_we) begin
                if (wr_idx < PAGES) begin
                    chk("waddr", 32'(mem_waddr), wr_idx);
                    chk("wdata", 32'(mem_wdata), 32'(exp_pg[wr_idx]));
                end else begin
                    chk("extra_write", 32'(mem_waddr), 32'hFFFF_FFFF);
                end
                wr_idx++;
            end
            if (cal_start) begin
                chk("cal_start_width", 32'(cal_prev), 0);
                ncal++;
            end
            if (done) begin
                ndone++;
                done_k = cyc - k0;
            end
            cal_prev = cal_start;
        end
    end

    // ---------------- job runner ----------------
    task automatic run_job(input int n, input bit hold, input bit md, input bit extra, input int abort_z);
        int nbad;
        bit aborted;
        int kk;
        wait_n = n;
        hold_hi = hold;
        mode_prev = md;
        @(posedge clk); #1;
        for (int i = 0; i < PAGES; i++) orig[i] = mem[i];
        for (int z = 0; z < PAGES; z++) begin
            logic [0:24] nb;
            nb = orig[(z + PAGES - 1) % PAGES];
            exp_pg[z] = md ? nb : (orig[z] ^ nb);
        end
        wr_idx = 0; ncal = 0; ndone = 0; done_k = -1; cal_prev = 1'b0;
        aborted = 1'b0;
        start = 1'b1;
        k0 = cyc;
        mon_en = 1'b1;
        for (int it = 0; it < 2000; it++) begin
            @(posedge clk); #1;
            if (ndone != 0) break;
            kk = cyc - k0;
            start = extra && (kk == 10 || kk == 200);
            if (kk == 5) chk("busy_mid", 32'(busy), 1);
            if (abort_z >= 0 && ncal == abort_z + 1 && wr_idx == abort_z) begin
                rst = 1'b0;
                #1;
                chk("abort_ctrl", 32'({busy, done, mem_we, cal_start}), 0);
                chk("abort_addr", 32'({mem_raddr, mem_waddr}), 0);
                chk("abort_wdata", 32'(mem_wdata), 0);
                chk("abort_cur", 32'(cur_page), 0);
                chk("abort_prev", 32'(prev_page), 0);
                aborted = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (aborted) begin
            repeat (3) @(posedge clk);
            #1;
            chk("abort_writes", wr_idx, abort_z);
            nbad = 0;
            for (int z = 0; z < PAGES; z++) begin
                if (z < abort_z && mem[z] !== exp_pg[z]) nbad++;
                if (z >= abort_z && mem[z] !== orig[z]) nbad++;
            end
            chk("abort_mem", nbad, 0);
            rst = 1'b1;
        end else begin
            chk("done_seen", ndone, 1);
            chk("done_cycle", done_k, hold ? 3 + PAGES * 5 : 3 + PAGES * (5 + n));
            chk("idle_after", 32'({busy, done}), 0);
            repeat (4) @(posedge clk);
            #1;
            chk("writes", wr_idx, PAGES);
            chk("done_pulses", ndone, 1);
            chk("cal_starts", ncal, PAGES);
            nbad = 0;
            for (int z = 0; z < PAGES; z++) if (mem[z] !== exp_pg[z]) nbad++;
            chk("mem_final", nbad, 0);
        end
        mon_en = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        start = 1'b0;
        #3 rst = 1'b0;
        #2;
        chk("reset_ctrl", 32'({busy, done, mem_we, cal_start}), 0);
        chk("reset_addr", 32'({mem_raddr, mem_waddr}), 0);
        chk("reset_data", 32'({mem_wdata, 7'd0}) | 32'(cur_page) | 32'(prev_page), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // page z = z, xor parity, N=1
        for (int i = 0; i < PAGES; i++) mem[i] <= 25'(i);
        run_job(1, 1'b0, 1'b0, 1'b0, -1);
        chk("page0_is_63", 32'(mem[0]), 63);
        chk("page37", 32'(mem[37]), 37 ^ 36);

        // random data, N=4, stray starts at cycles 10 and 200
        for (int i = 0; i < PAGES; i++) mem[i] <= 25'($urandom);
        run_job(4, 1'b0, 1'b0, 1'b1, -1);

        // random data, cal_finish held high
        for (int i = 0; i < PAGES; i++) mem[i] <= 25'($urandom);
        run_job(1, 1'b1, 1'b0, 1'b0, -1);

        // all ones, parity returns prev_page
        for (int i = 0; i < PAGES; i++) mem[i] <= 25'h1FFFFFF;
        run_job($urandom_range(1, 3), 1'b0, 1'b1, 1'b0, -1);
        chk("ones_page63", 32'(mem[63]), 32'h1FFFFFF);

        // reset during WAIT of page 20, then a full restart from page 0
        for (int i = 0; i < PAGES; i++) mem[i] <= 25'($urandom);
        run_job($urandom_range(1, 3), 1'b0, 1'b0, 1'b0, 20);
        run_job($urandom_range(1, 3), 1'b0, 1'b0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
